// File: rtl/key_space_dispatcher.sv
// Purpose : hands fixed-size key chunks to idle RC4 search cores round-robin, collects found reports, broadcasts halt.
// Latency : start is registered, so the first grant follows the start edge by two clocks; later grants are one clock after core_req is sampled.
// Backpressure: a chunk is only issued to a core that holds core_req high; without requesters the next chunk simply waits.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   start                   - one-cycle pulse, honoured in IDLE only
//   core_req / core_found   - per-core idle level / per-core found pulse
//   core_key                - per-core candidate key, slice [i*KEY_WIDTH +: KEY_WIDTH]
//   core_grant              - one-hot grant pulse, with grant_base / grant_last describing the chunk
//   halt, found, not_found  - sticky terminal status until reset
//   found_key               - winning key (zero unless found)
//   busy                    - search in progress (dispatching or draining)
module key_space_dispatcher #(
  parameter int                   NUM_CORES  = 4,
  parameter int                   KEY_WIDTH  = 24,
  parameter int                   CHUNK_BITS = 16,
  parameter logic [KEY_WIDTH-1:0] MIN_KEY    = 24'h00_00_00,
  parameter logic [KEY_WIDTH-1:0] MAX_KEY    = 24'h3F_FF_FF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic [NUM_CORES-1:0]           core_grant,
  output logic [KEY_WIDTH-1:0]           grant_base,
  output logic [KEY_WIDTH-1:0]           grant_last,
  output logic                           halt,
  output logic                           found,
  output logic                           not_found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic                           busy
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Key arithmetic is one bit wider than the key so that stepping past the
  // top of the key space shows up as a carry rather than a wrap to zero.
  localparam logic [KEY_WIDTH:0] LP_CHUNK = (KEY_WIDTH+1)'(1) << CHUNK_BITS;
  localparam logic [KEY_WIDTH:0] LP_MAX   = {1'b0, MAX_KEY};
  localparam logic [KEY_WIDTH:0] LP_MIN   = {1'b0, MIN_KEY};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE_FOUND,
    S_DONE_EMPTY
  } state_t;

  state_t                 r_state;
  logic                   r_start;
  logic [KEY_WIDTH:0]     r_next_base;
  logic [PW-1:0]          r_rr_ptr;
  logic [NUM_CORES-1:0]   r_core_grant;
  logic [KEY_WIDTH-1:0]   r_grant_base;
  logic [KEY_WIDTH-1:0]   r_grant_last;
  logic                   r_halt;
  logic                   r_found;
  logic                   r_not_found;
  logic [KEY_WIDTH-1:0]   r_found_key;
  logic                   r_busy;

  logic [NUM_CORES-1:0]   w_req_eff;
  logic                   w_gnt_vld;
  logic [PW-1:0]          w_gnt_idx;
  logic [NUM_CORES-1:0]   w_gnt_onehot;
  logic [PW-1:0]          w_rr_next;
  logic                   w_fnd_any;
  logic [KEY_WIDTH-1:0]   w_fnd_key;
  logic [KEY_WIDTH:0]     w_chunk_end;
  logic [KEY_WIDTH:0]     w_base_sum;
  logic [KEY_WIDTH-1:0]   w_last;
  logic                   w_exhaust;

  // A core granted last cycle still shows its old request for one cycle
  // (it drops req one clock after seeing the grant), so hide it.
  assign w_req_eff = core_req & ~r_core_grant;

  // Round-robin: first effective requester at or after r_rr_ptr, cyclic.
  always_comb begin : p_arb
    int v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_CORES;
      if (!w_gnt_vld && w_req_eff[PW'(v_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(v_idx);
      end
    end
  end

  assign w_gnt_onehot = NUM_CORES'(1) << w_gnt_idx;
  assign w_rr_next    = (w_gnt_idx == PW'(NUM_CORES - 1)) ? '0 : w_gnt_idx + PW'(1);

  // Lowest-index found report wins: scan downwards so the last hit is the lowest.
  always_comb begin
    w_fnd_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        w_fnd_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  assign w_fnd_any = |core_found;

  // Chunk bounds; the last chunk is clipped to MAX_KEY. r_next_base never
  // exceeds MAX_KEY while dispatching, so the clipped value fits the key width.
  assign w_chunk_end = r_next_base + (LP_CHUNK - (KEY_WIDTH+1)'(1));
  assign w_last      = (w_chunk_end > LP_MAX) ? MAX_KEY : w_chunk_end[KEY_WIDTH-1:0];
  assign w_base_sum  = r_next_base + LP_CHUNK;
  assign w_exhaust   = (w_base_sum > LP_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_next_base  <= '0;
      r_rr_ptr     <= '0;
      r_core_grant <= '0;
      r_grant_base <= '0;
      r_grant_last <= '0;
      r_halt       <= 1'b0;
      r_found      <= 1'b0;
      r_not_found  <= 1'b0;
      r_found_key  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_start      <= start;
      r_core_grant <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_start) begin
            r_state     <= S_DISPATCH;
            r_next_base <= LP_MIN;
            r_rr_ptr    <= '0;
            r_busy      <= 1'b1;
          end
        end

        S_DISPATCH: begin
          // A found report pre-empts any grant pending in the same cycle.
          if (w_fnd_any) begin
            r_state     <= S_DONE_FOUND;
            r_halt      <= 1'b1;
            r_found     <= 1'b1;
            r_found_key <= w_fnd_key;
            r_busy      <= 1'b0;
          end else if (w_gnt_vld) begin
            r_core_grant <= w_gnt_onehot;
            r_grant_base <= r_next_base[KEY_WIDTH-1:0];
            r_grant_last <= w_last;
            r_next_base  <= w_base_sum;
            r_rr_ptr     <= w_rr_next;
            if (w_exhaust) begin
              r_state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Cores may still be searching their last chunks; wait until every
          // core is back to requesting before declaring the range exhausted.
          if (w_fnd_any) begin
            r_state     <= S_DONE_FOUND;
            r_halt      <= 1'b1;
            r_found     <= 1'b1;
            r_found_key <= w_fnd_key;
            r_busy      <= 1'b0;
          end else if (&core_req) begin
            r_state     <= S_DONE_EMPTY;
            r_halt      <= 1'b1;
            r_not_found <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          // DONE_FOUND / DONE_EMPTY are terminal until reset.
        end
      endcase
    end
  end

  assign core_grant = r_core_grant;
  assign grant_base = r_grant_base;
  assign grant_last = r_grant_last;
  assign halt       = r_halt;
  assign found      = r_found;
  assign not_found  = r_not_found;
  assign found_key  = r_found_key;
  assign busy       = r_busy;

endmodule

// File: tb/tb_key_space_dispatcher.sv
// Directed bench for key_space_dispatcher: three instances with different key ranges share stimulus.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled at the same point.
// Each test task resets all instances and checks only the instance it targets.
module tb_key_space_dispatcher;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [3:0]  req;
  logic [3:0]  fnd;
  logic [95:0] keys;

  logic [3:0]  a_grant, b_grant, c_grant;
  logic [23:0] a_base, b_base, c_base;
  logic [23:0] a_last, b_last, c_last;
  logic        a_halt, b_halt, c_halt;
  logic        a_found, b_found, c_found;
  logic        a_nf, b_nf, c_nf;
  logic [23:0] a_fkey, b_fkey, c_fkey;
  logic        a_busy, b_busy, c_busy;

  int n_checks = 0;
  int n_errors = 0;

  key_space_dispatcher #(.NUM_CORES(4), .KEY_WIDTH(24), .CHUNK_BITS(16),
                         .MIN_KEY(24'h000000), .MAX_KEY(24'h03FFFF)) u_a (
    .clock(clk), .reset(rst), .start(start), .core_req(req), .core_found(fnd), .core_key(keys),
    .core_grant(a_grant), .grant_base(a_base), .grant_last(a_last), .halt(a_halt),
    .found(a_found), .not_found(a_nf), .found_key(a_fkey), .busy(a_busy));

  key_space_dispatcher #(.NUM_CORES(4), .KEY_WIDTH(24), .CHUNK_BITS(16),
                         .MIN_KEY(24'h000000), .MAX_KEY(24'h028000)) u_b (
    .clock(clk), .reset(rst), .start(start), .core_req(req), .core_found(fnd), .core_key(keys),
    .core_grant(b_grant), .grant_base(b_base), .grant_last(b_last), .halt(b_halt),
    .found(b_found), .not_found(b_nf), .found_key(b_fkey), .busy(b_busy));

  key_space_dispatcher #(.NUM_CORES(4), .KEY_WIDTH(24), .CHUNK_BITS(16),
                         .MIN_KEY(24'h000000), .MAX_KEY(24'hFFFFFF)) u_c (
    .clock(clk), .reset(rst), .start(start), .core_req(req), .core_found(fnd), .core_key(keys),
    .core_grant(c_grant), .grant_base(c_base), .grant_last(c_last), .halt(c_halt),
    .found(c_found), .not_found(c_nf), .found_key(c_fkey), .busy(c_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; req = 4'h0; fnd = 4'h0; keys = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  // start is sampled at the next edge; two edges later the first grant can appear.
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; req = 4'hF; fnd = 4'hF; keys = {4{24'hABCDEF}};
    tick; tick;
    n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL reset_grant: got %h want 0", a_grant); end
    n_checks++; if (a_base !== 24'h0) begin n_errors++; $display("FAIL reset_base: got %h want 0", a_base); end
    n_checks++; if (a_last !== 24'h0) begin n_errors++; $display("FAIL reset_last: got %h want 0", a_last); end
    n_checks++; if ({a_halt, a_found, a_nf, a_busy} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", {a_halt, a_found, a_nf, a_busy}); end
    n_checks++; if (a_fkey !== 24'h0) begin n_errors++; $display("FAIL reset_fkey: got %h want 0", a_fkey); end
    // core_found while idle must be ignored
    rst = 1'b0; start = 1'b0;
    tick; tick; tick;
    n_checks++; if ({a_halt, a_found, a_busy} !== 3'b000) begin n_errors++; $display("FAIL idle_found_ignored: got %b want 000", {a_halt, a_found, a_busy}); end
    n_checks++; if (a_fkey !== 24'h0) begin n_errors++; $display("FAIL idle_fkey: got %h want 0", a_fkey); end
    fnd = 4'h0;
  endtask

  task automatic test_exhaust;
    int gcount;
    logic [31:0] eb;
    do_reset;
    req = 4'hF;
    pulse_start;
    gcount = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick;
      if (a_grant !== 4'h0) begin
        eb = gcount * 32'h10000;
        n_checks++; if (a_grant !== (4'b0001 << (gcount % 4))) begin n_errors++; $display("FAIL exh_grant%0d: got %b want %b", gcount, a_grant, 4'b0001 << (gcount % 4)); end
        n_checks++; if (a_base !== eb[23:0]) begin n_errors++; $display("FAIL exh_base%0d: got %h want %h", gcount, a_base, eb[23:0]); end
        eb = eb + 32'hFFFF;
        n_checks++; if (a_last !== eb[23:0]) begin n_errors++; $display("FAIL exh_last%0d: got %h want %h", gcount, a_last, eb[23:0]); end
        gcount++;
      end
    end
    n_checks++; if (gcount !== 4) begin n_errors++; $display("FAIL exh_count: got %0d want 4", gcount); end
    n_checks++; if ({a_nf, a_halt, a_found, a_busy} !== 4'b1100) begin n_errors++; $display("FAIL exh_flags: got %b want 1100", {a_nf, a_halt, a_found, a_busy}); end
    n_checks++; if (a_fkey !== 24'h0) begin n_errors++; $display("FAIL exh_fkey: got %h want 0", a_fkey); end
  endtask

  task automatic test_single_core;
    int gcount;
    logic [31:0] eb;
    do_reset;
    req = 4'b0100;
    pulse_start;
    gcount = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      tick;
      if (b_grant !== 4'h0) begin
        eb = gcount * 32'h10000;
        // core 2 keeps req high; masking leaves a gap after every grant
        n_checks++; if (cyc !== 1 + 2 * gcount) begin n_errors++; $display("FAIL one_cycle%0d: got %0d want %0d", gcount, cyc, 1 + 2 * gcount); end
        n_checks++; if (b_grant !== 4'b0100) begin n_errors++; $display("FAIL one_grant%0d: got %b want 0100", gcount, b_grant); end
        n_checks++; if (b_base !== eb[23:0]) begin n_errors++; $display("FAIL one_base%0d: got %h want %h", gcount, b_base, eb[23:0]); end
        eb = (gcount < 2) ? eb + 32'hFFFF : 32'h028000;
        n_checks++; if (b_last !== eb[23:0]) begin n_errors++; $display("FAIL one_last%0d: got %h want %h", gcount, b_last, eb[23:0]); end
        gcount++;
      end
    end
    n_checks++; if (gcount !== 3) begin n_errors++; $display("FAIL one_count: got %0d want 3", gcount); end
    n_checks++; if ({b_busy, b_nf, b_halt} !== 3'b100) begin n_errors++; $display("FAIL one_drain_hold: got %b want 100", {b_busy, b_nf, b_halt}); end
    req = 4'hF;
    tick;
    n_checks++; if ({b_busy, b_nf, b_halt} !== 3'b011) begin n_errors++; $display("FAIL one_empty: got %b want 011", {b_busy, b_nf, b_halt}); end
  endtask

  task automatic test_found_multi;
    do_reset;
    req = 4'hF;
    pulse_start;
    tick; tick;
    n_checks++; if (a_grant !== 4'b0001) begin n_errors++; $display("FAIL fm_first_grant: got %b want 0001", a_grant); end
    fnd = 4'b1010;
    keys = {24'h3ABCDE, 24'h222222, 24'h123456, 24'h111111};
    n_checks++; if (a_found !== 1'b0) begin n_errors++; $display("FAIL fm_found_early: got %b want 0", a_found); end
    tick;
    fnd = 4'h0;
    n_checks++; if ({a_found, a_halt, a_nf, a_busy} !== 4'b1100) begin n_errors++; $display("FAIL fm_flags: got %b want 1100", {a_found, a_halt, a_nf, a_busy}); end
    n_checks++; if (a_fkey !== 24'h123456) begin n_errors++; $display("FAIL fm_key: got %h want 123456", a_fkey); end
    n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL fm_grant_supp: got %b want 0", a_grant); end
    start = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick;
      start = 1'b0;
      n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL fm_no_grant%0d: got %b want 0", cyc, a_grant); end
    end
    n_checks++; if ({a_found, a_halt} !== 2'b11 || a_fkey !== 24'h123456) begin n_errors++; $display("FAIL fm_sticky: got %b key %h want 11 key 123456", {a_found, a_halt}, a_fkey); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if ({a_found, a_halt} !== 2'b00 || a_fkey !== 24'h0) begin n_errors++; $display("FAIL fm_reset_clear: got %b key %h want 00 key 0", {a_found, a_halt}, a_fkey); end
  endtask

  task automatic test_found_clash;
    do_reset;
    req = 4'b0001;
    pulse_start;
    tick;
    n_checks++; if (a_busy !== 1'b1 || a_grant !== 4'h0) begin n_errors++; $display("FAIL fc_pre: got busy %b grant %b want 1 0000", a_busy, a_grant); end
    fnd = 4'b0100;
    keys = {24'h0, 24'h0BEEF0, 24'h0, 24'h0};
    tick;
    fnd = 4'h0;
    n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL fc_grant: got %b want 0", a_grant); end
    n_checks++; if ({a_found, a_halt} !== 2'b11) begin n_errors++; $display("FAIL fc_found: got %b want 11", {a_found, a_halt}); end
    n_checks++; if (a_fkey !== 24'h0BEEF0) begin n_errors++; $display("FAIL fc_key: got %h want 0beef0", a_fkey); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick;
      n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL fc_after%0d: got %b want 0", cyc, a_grant); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'hF;
    pulse_start;
    tick; tick; tick; tick;
    n_checks++; if (a_grant !== 4'b0100 || a_base !== 24'h020000) begin n_errors++; $display("FAIL rm_pre: got %b base %h want 0100 base 020000", a_grant, a_base); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++; if (a_grant !== 4'h0 || a_busy !== 1'b0 || a_base !== 24'h0 || a_halt !== 1'b0) begin n_errors++; $display("FAIL rm_cleared: got grant %b busy %b base %h halt %b want 0", a_grant, a_busy, a_base, a_halt); end
    pulse_start;
    tick;
    n_checks++; if (a_grant !== 4'h0) begin n_errors++; $display("FAIL rm_latency: got %b want 0", a_grant); end
    tick;
    n_checks++; if (a_grant !== 4'b0001) begin n_errors++; $display("FAIL rm_rr_restart: got %b want 0001", a_grant); end
    n_checks++; if (a_base !== 24'h0 || a_last !== 24'h00FFFF) begin n_errors++; $display("FAIL rm_base: got %h..%h want 000000..00ffff", a_base, a_last); end
  endtask

  task automatic test_carry;
    int gcount;
    logic [31:0] eb;
    logic [23:0] lastb;
    logic [23:0] lastl;
    do_reset;
    req = 4'hF;
    pulse_start;
    gcount = 0; lastb = '0; lastl = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick;
      if (c_grant !== 4'h0) begin
        eb = gcount * 32'h10000;
        n_checks++; if (c_grant !== (4'b0001 << (gcount % 4))) begin n_errors++; $display("FAIL cy_rot%0d: got %b want %b", gcount, c_grant, 4'b0001 << (gcount % 4)); end
        n_checks++; if (c_base !== eb[23:0]) begin n_errors++; $display("FAIL cy_base%0d: got %h want %h", gcount, c_base, eb[23:0]); end
        lastb = c_base;
        lastl = c_last;
        gcount++;
      end
      if (c_nf === 1'b1) break;
    end
    n_checks++; if (gcount !== 256) begin n_errors++; $display("FAIL cy_count: got %0d want 256", gcount); end
    n_checks++; if (lastb !== 24'hFF0000) begin n_errors++; $display("FAIL cy_lastbase: got %h want ff0000", lastb); end
    n_checks++; if (lastl !== 24'hFFFFFF) begin n_errors++; $display("FAIL cy_lastlast: got %h want ffffff", lastl); end
    n_checks++; if ({c_nf, c_halt, c_found} !== 3'b110) begin n_errors++; $display("FAIL cy_flags: got %b want 110", {c_nf, c_halt, c_found}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; req = 4'h0; fnd = 4'h0; keys = '0;
    test_reset;
    test_exhaust;
    test_single_core;
    test_found_multi;
    test_found_clash;
    test_reset_mid;
    test_carry;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
